// File: rtl/peripheral_biu_arbiter.sv
// Two-requester BIU arbiter sharing one slave BIU port (m0 = data side, m1 = instruction side).
// Define BIU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise m0 has fixed priority.
module peripheral_biu_arbiter #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_biu_stb_i,
    input  logic [PLEN-1:0] m0_biu_adri_i,
    input  logic [2:0]      m0_biu_size_i,
    input  logic [2:0]      m0_biu_type_i,
    input  logic [2:0]      m0_biu_prot_i,
    input  logic            m0_biu_lock_i,
    input  logic            m0_biu_we_i,
    input  logic [XLEN-1:0] m0_biu_d_i,
    output logic            m0_biu_stb_ack_o,
    output logic            m0_biu_d_ack_o,
    output logic            m0_biu_ack_o,
    output logic            m0_biu_err_o,
    output logic [XLEN-1:0] m0_biu_q_o,
    output logic [PLEN-1:0] m0_biu_adro_o,

    input  logic            m1_biu_stb_i,
    input  logic [PLEN-1:0] m1_biu_adri_i,
    input  logic [2:0]      m1_biu_size_i,
    input  logic [2:0]      m1_biu_type_i,
    input  logic [2:0]      m1_biu_prot_i,
    input  logic            m1_biu_lock_i,
    input  logic            m1_biu_we_i,
    input  logic [XLEN-1:0] m1_biu_d_i,
    output logic            m1_biu_stb_ack_o,
    output logic            m1_biu_d_ack_o,
    output logic            m1_biu_ack_o,
    output logic            m1_biu_err_o,
    output logic [XLEN-1:0] m1_biu_q_o,
    output logic [PLEN-1:0] m1_biu_adro_o,

    output logic            s_biu_stb_o,
    output logic [PLEN-1:0] s_biu_adri_o,
    output logic [2:0]      s_biu_size_o,
    output logic [2:0]      s_biu_type_o,
    output logic [2:0]      s_biu_prot_o,
    output logic            s_biu_lock_o,
    output logic            s_biu_we_o,
    output logic [XLEN-1:0] s_biu_d_o,
    input  logic            s_biu_stb_ack_i,
    input  logic            s_biu_d_ack_i,
    input  logic            s_biu_ack_i,
    input  logic            s_biu_err_i,
    input  logic [XLEN-1:0] s_biu_q_i,
    input  logic [PLEN-1:0] s_biu_adro_i
);

    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] WRAP4  = 3'b010;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] WRAP8  = 3'b100;
    localparam logic [2:0] INCR8  = 3'b101;
    localparam logic [2:0] WRAP16 = 3'b110;
    localparam logic [2:0] INCR16 = 3'b111;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] beatCnt_q, beatCnt_d;
    logic       lockHold_q, lockHold_d;
`ifdef BIU_ARB_ROUND_ROBIN_EN
    logic       rrPtr_q, rrPtr_d;
`endif

    logic m0Elig, m1Elig, grantValid, winner, sel, accept;
    logic ownerStb, selLock;
    logic hsStbAck, hsDAck, hsAck, hsErr;

    // Beats remaining after the first one, derived from the burst type
    function automatic logic [3:0] burstLast(input logic [2:0] burstType);
        case (burstType)
            SINGLE, INCR:   burstLast = 4'd0;
            WRAP4, INCR4:   burstLast = 4'd3;
            WRAP8, INCR8:   burstLast = 4'd7;
            WRAP16, INCR16: burstLast = 4'd15;
            default:        burstLast = 4'd0;
        endcase
    endfunction

    // A held lock restricts eligibility to the previous owner
    assign m0Elig     = m0_biu_stb_i & (~lockHold_q | ~owner_q);
    assign m1Elig     = m1_biu_stb_i & (~lockHold_q |  owner_q);
    assign grantValid = m0Elig | m1Elig;

`ifdef BIU_ARB_ROUND_ROBIN_EN
    assign winner = (m0Elig & m1Elig) ? rrPtr_q : (~m0Elig & m1Elig);
`else
    assign winner = ~m0Elig & m1Elig;
`endif

    assign sel      = (state_q == BUSY) ? owner_q : winner;
    assign accept   = (state_q == IDLE) & grantValid & s_biu_stb_ack_i;
    assign ownerStb = owner_q ? m1_biu_stb_i : m0_biu_stb_i;
    assign selLock  = sel ? m1_biu_lock_i : m0_biu_lock_i;

    always_comb begin
        if (sel) begin
            s_biu_adri_o = m1_biu_adri_i;
            s_biu_size_o = m1_biu_size_i;
            s_biu_type_o = m1_biu_type_i;
            s_biu_prot_o = m1_biu_prot_i;
            s_biu_lock_o = m1_biu_lock_i;
            s_biu_we_o   = m1_biu_we_i;
            s_biu_d_o    = m1_biu_d_i;
        end else begin
            s_biu_adri_o = m0_biu_adri_i;
            s_biu_size_o = m0_biu_size_i;
            s_biu_type_o = m0_biu_type_i;
            s_biu_prot_o = m0_biu_prot_i;
            s_biu_lock_o = m0_biu_lock_i;
            s_biu_we_o   = m0_biu_we_i;
            s_biu_d_o    = m0_biu_d_i;
        end
    end

    // Handshakes are forced low while reset is asserted
    always_comb begin
        s_biu_stb_o = 1'b0;
        hsStbAck    = 1'b0;
        hsDAck      = 1'b0;
        hsAck       = 1'b0;
        hsErr       = 1'b0;
        if (rst) begin
            if (state_q == IDLE) begin
                s_biu_stb_o = grantValid;
                hsStbAck    = grantValid & s_biu_stb_ack_i;
                if (accept) begin
                    hsDAck = s_biu_d_ack_i;
                    hsAck  = s_biu_ack_i;
                    hsErr  = s_biu_err_i;
                end
            end else begin
                hsDAck = s_biu_d_ack_i;
                hsAck  = s_biu_ack_i;
                hsErr  = s_biu_err_i;
            end
        end
    end

    assign m0_biu_stb_ack_o = hsStbAck & ~sel;
    assign m0_biu_d_ack_o   = hsDAck   & ~sel;
    assign m0_biu_ack_o     = hsAck    & ~sel;
    assign m0_biu_err_o     = hsErr    & ~sel;
    assign m1_biu_stb_ack_o = hsStbAck &  sel;
    assign m1_biu_d_ack_o   = hsDAck   &  sel;
    assign m1_biu_ack_o     = hsAck    &  sel;
    assign m1_biu_err_o     = hsErr    &  sel;

    assign m0_biu_q_o    = s_biu_q_i;
    assign m1_biu_q_o    = s_biu_q_i;
    assign m0_biu_adro_o = s_biu_adro_i;
    assign m1_biu_adro_o = s_biu_adro_i;

    // Errors end the burst immediately; the final ack returns to IDLE and latches the lock
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beatCnt_d  = beatCnt_q;
        lockHold_d = lockHold_q;
`ifdef BIU_ARB_ROUND_ROBIN_EN
        rrPtr_d    = rrPtr_q;
`endif
        case (state_q)
            IDLE: begin
                if (lockHold_q && !ownerStb) begin
                    lockHold_d = 1'b0;
                end
                if (accept) begin
                    state_d   = BUSY;
                    owner_d   = winner;
                    beatCnt_d = burstLast(s_biu_type_o);
`ifdef BIU_ARB_ROUND_ROBIN_EN
                    rrPtr_d   = ~winner;
`endif
                end
            end
            BUSY: begin
                if (s_biu_err_i) begin
                    state_d    = IDLE;
                    beatCnt_d  = 4'd0;
                    lockHold_d = selLock;
                end else if (s_biu_ack_i) begin
                    if (beatCnt_q == 4'd0) begin
                        state_d    = IDLE;
                        lockHold_d = selLock;
                    end else begin
                        beatCnt_d = beatCnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            beatCnt_q  <= 4'd0;
            lockHold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beatCnt_q  <= beatCnt_d;
            lockHold_q <= lockHold_d;
        end
    end

`ifdef BIU_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rrPtr_q <= 1'b0;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end
`endif

endmodule

// File: tb/tb_peripheral_biu_arbiter.sv
// Directed testbench for peripheral_biu_arbiter; expectations adapt to BIU_ARB_ROUND_ROBIN_EN.
module tb_peripheral_biu_arbiter;

    localparam int XLEN = 64;
    localparam int PLEN = 64;

    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] WRAP4  = 3'b010;
    localparam logic [2:0] INCR8  = 3'b101;
    localparam logic [2:0] INCR16 = 3'b111;

    logic            clk, rst;
    logic            m0_biu_stb_i, m0_biu_lock_i, m0_biu_we_i;
    logic [PLEN-1:0] m0_biu_adri_i;
    logic [2:0]      m0_biu_size_i, m0_biu_type_i, m0_biu_prot_i;
    logic [XLEN-1:0] m0_biu_d_i;
    logic            m0_biu_stb_ack_o, m0_biu_d_ack_o, m0_biu_ack_o, m0_biu_err_o;
    logic [XLEN-1:0] m0_biu_q_o;
    logic [PLEN-1:0] m0_biu_adro_o;
    logic            m1_biu_stb_i, m1_biu_lock_i, m1_biu_we_i;
    logic [PLEN-1:0] m1_biu_adri_i;
    logic [2:0]      m1_biu_size_i, m1_biu_type_i, m1_biu_prot_i;
    logic [XLEN-1:0] m1_biu_d_i;
    logic            m1_biu_stb_ack_o, m1_biu_d_ack_o, m1_biu_ack_o, m1_biu_err_o;
    logic [XLEN-1:0] m1_biu_q_o;
    logic [PLEN-1:0] m1_biu_adro_o;
    logic            s_biu_stb_o, s_biu_lock_o, s_biu_we_o;
    logic [PLEN-1:0] s_biu_adri_o;
    logic [2:0]      s_biu_size_o, s_biu_type_o, s_biu_prot_o;
    logic [XLEN-1:0] s_biu_d_o;
    logic            s_biu_stb_ack_i, s_biu_d_ack_i, s_biu_ack_i, s_biu_err_i;
    logic [XLEN-1:0] s_biu_q_i;
    logic [PLEN-1:0] s_biu_adro_i;

    logic [8:0] hs;
    int errors = 0;
    int checks = 0;

    peripheral_biu_arbiter #(.XLEN(XLEN), .PLEN(PLEN)) dut (
        .clk(clk), .rst(rst),
        .m0_biu_stb_i(m0_biu_stb_i), .m0_biu_adri_i(m0_biu_adri_i), .m0_biu_size_i(m0_biu_size_i),
        .m0_biu_type_i(m0_biu_type_i), .m0_biu_prot_i(m0_biu_prot_i), .m0_biu_lock_i(m0_biu_lock_i),
        .m0_biu_we_i(m0_biu_we_i), .m0_biu_d_i(m0_biu_d_i),
        .m0_biu_stb_ack_o(m0_biu_stb_ack_o), .m0_biu_d_ack_o(m0_biu_d_ack_o), .m0_biu_ack_o(m0_biu_ack_o),
        .m0_biu_err_o(m0_biu_err_o), .m0_biu_q_o(m0_biu_q_o), .m0_biu_adro_o(m0_biu_adro_o),
        .m1_biu_stb_i(m1_biu_stb_i), .m1_biu_adri_i(m1_biu_adri_i), .m1_biu_size_i(m1_biu_size_i),
        .m1_biu_type_i(m1_biu_type_i), .m1_biu_prot_i(m1_biu_prot_i), .m1_biu_lock_i(m1_biu_lock_i),
        .m1_biu_we_i(m1_biu_we_i), .m1_biu_d_i(m1_biu_d_i),
        .m1_biu_stb_ack_o(m1_biu_stb_ack_o), .m1_biu_d_ack_o(m1_biu_d_ack_o), .m1_biu_ack_o(m1_biu_ack_o),
        .m1_biu_err_o(m1_biu_err_o), .m1_biu_q_o(m1_biu_q_o), .m1_biu_adro_o(m1_biu_adro_o),
        .s_biu_stb_o(s_biu_stb_o), .s_biu_adri_o(s_biu_adri_o), .s_biu_size_o(s_biu_size_o),
        .s_biu_type_o(s_biu_type_o), .s_biu_prot_o(s_biu_prot_o), .s_biu_lock_o(s_biu_lock_o),
        .s_biu_we_o(s_biu_we_o), .s_biu_d_o(s_biu_d_o),
        .s_biu_stb_ack_i(s_biu_stb_ack_i), .s_biu_d_ack_i(s_biu_d_ack_i), .s_biu_ack_i(s_biu_ack_i),
        .s_biu_err_i(s_biu_err_i), .s_biu_q_i(s_biu_q_i), .s_biu_adro_i(s_biu_adro_i)
    );

    // Handshake snapshot: {m0 stb_ack,d_ack,ack,err, m1 stb_ack,d_ack,ack,err, s stb}
    assign hs = {m0_biu_stb_ack_o, m0_biu_d_ack_o, m0_biu_ack_o, m0_biu_err_o,
                 m1_biu_stb_ack_o, m1_biu_d_ack_o, m1_biu_ack_o, m1_biu_err_o, s_biu_stb_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] timeout");
    end

    task automatic clearInputs();
        m0_biu_stb_i = 0; m0_biu_lock_i = 0; m0_biu_we_i = 0; m0_biu_adri_i = '0;
        m0_biu_size_i = 0; m0_biu_type_i = SINGLE; m0_biu_prot_i = 0; m0_biu_d_i = '0;
        m1_biu_stb_i = 0; m1_biu_lock_i = 0; m1_biu_we_i = 0; m1_biu_adri_i = '0;
        m1_biu_size_i = 0; m1_biu_type_i = SINGLE; m1_biu_prot_i = 0; m1_biu_d_i = '0;
        s_biu_stb_ack_i = 0; s_biu_d_ack_i = 0; s_biu_ack_i = 0; s_biu_err_i = 0;
        s_biu_q_i = '0; s_biu_adro_i = '0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        clearInputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        m0_biu_stb_i = 1; m1_biu_stb_i = 1;
        s_biu_stb_ack_i = 1; s_biu_ack_i = 1; s_biu_d_ack_i = 1; s_biu_err_i = 1;
        #1;
        checks++;
        if (hs !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_during hs=%b expected=%b", hs, 9'b0);
        end
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        m0_biu_stb_i = 1; m0_biu_adri_i = 64'h55;
        #1;
        checks++;
        if (hs !== 9'b0000_0000_1 || s_biu_adri_o !== 64'h55) begin
            errors++;
            $display("[TB] FAIL reset_idle hs=%b adr=%h expected hs=%b adr=%h", hs, s_biu_adri_o, 9'b0000_0000_1, 64'h55);
        end
    endtask

    task automatic test_single_m0();
        applyReset();
        @(negedge clk);
        m0_biu_stb_i = 1; m0_biu_adri_i = 64'h100; m0_biu_type_i = SINGLE;
        m0_biu_size_i = 3'b011; m0_biu_prot_i = 3'b010; m0_biu_we_i = 0; m0_biu_d_i = 64'hA5;
        m1_biu_adri_i = 64'h999; m1_biu_d_i = 64'h77;
        s_biu_stb_ack_i = 1;
        #1;
        checks++;
        if (hs !== 9'b1000_0000_1) begin
            errors++;
            $display("[TB] FAIL single_accept hs=%b expected=%b", hs, 9'b1000_0000_1);
        end
        checks++;
        if ({s_biu_adri_o, s_biu_size_o, s_biu_type_o, s_biu_prot_o, s_biu_we_o} !==
            {64'h100, 3'b011, SINGLE, 3'b010, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_fields adr=%h size=%b type=%b prot=%b we=%b expected adr=100 size=011 type=000 prot=010 we=0",
                     s_biu_adri_o, s_biu_size_o, s_biu_type_o, s_biu_prot_o, s_biu_we_o);
        end
        @(negedge clk);
        m0_biu_stb_i = 0; m0_biu_d_i = 64'h5A;
        s_biu_stb_ack_i = 0; s_biu_ack_i = 1; s_biu_d_ack_i = 1;
        s_biu_q_i = 64'hDEAD_BEEF_0123_4567; s_biu_adro_i = 64'h100;
        #1;
        checks++;
        if (hs !== 9'b0110_0000_0) begin
            errors++;
            $display("[TB] FAIL single_ack hs=%b expected=%b", hs, 9'b0110_0000_0);
        end
        checks++;
        if (m0_biu_q_o !== 64'hDEAD_BEEF_0123_4567 || m1_biu_q_o !== 64'hDEAD_BEEF_0123_4567 ||
            m0_biu_adro_o !== 64'h100 || m1_biu_adro_o !== 64'h100) begin
            errors++;
            $display("[TB] FAIL single_broadcast q0=%h q1=%h a0=%h a1=%h expected q=deadbeef01234567 a=100",
                     m0_biu_q_o, m1_biu_q_o, m0_biu_adro_o, m1_biu_adro_o);
        end
        checks++;
        if (s_biu_d_o !== 64'h5A || s_biu_adri_o !== 64'h100) begin
            errors++;
            $display("[TB] FAIL single_owner_hold d=%h adr=%h expected d=5a adr=100", s_biu_d_o, s_biu_adri_o);
        end
        @(negedge clk);
        s_biu_ack_i = 0; s_biu_d_ack_i = 0;
        m0_biu_stb_i = 1;
        #1;
        checks++;
        if (hs !== 9'b0000_0000_1) begin
            errors++;
            $display("[TB] FAIL single_back_idle hs=%b expected=%b", hs, 9'b0000_0000_1);
        end
    endtask

    task automatic test_simultaneous();
        logic g;
        applyReset();
        @(negedge clk);
        m0_biu_stb_i = 1; m0_biu_adri_i = 64'h10;
        m1_biu_stb_i = 1; m1_biu_adri_i = 64'h20;
        for (int i = 0; i < 4; i++) begin
`ifdef BIU_ARB_ROUND_ROBIN_EN
            g = ((i % 2) == 1);
`else
            g = 1'b0;
`endif
            @(negedge clk);
            s_biu_stb_ack_i = 1; s_biu_ack_i = 0;
            #1;
            checks++;
            if ({m0_biu_stb_ack_o, m1_biu_stb_ack_o} !== (g ? 2'b01 : 2'b10) ||
                s_biu_adri_o !== (g ? 64'h20 : 64'h10)) begin
                errors++;
                $display("[TB] FAIL simul_grant%0d stb_ack=%b adr=%h expected stb_ack=%b adr=%h", i,
                         {m0_biu_stb_ack_o, m1_biu_stb_ack_o}, s_biu_adri_o,
                         (g ? 2'b01 : 2'b10), (g ? 64'h20 : 64'h10));
            end
            @(negedge clk);
            s_biu_stb_ack_i = 0; s_biu_ack_i = 1;
            #1;
            checks++;
            if ({m0_biu_ack_o, m1_biu_ack_o} !== (g ? 2'b01 : 2'b10)) begin
                errors++;
                $display("[TB] FAIL simul_ack%0d ack=%b expected=%b", i, {m0_biu_ack_o, m1_biu_ack_o}, (g ? 2'b01 : 2'b10));
            end
        end
    endtask

    task automatic test_incr8_burst();
        applyReset();
        @(negedge clk);
        m1_biu_stb_i = 1; m1_biu_adri_i = 64'h200; m1_biu_type_i = INCR8;
        m0_biu_adri_i = 64'h300;
        s_biu_stb_ack_i = 1;
        #1;
        checks++;
        if (hs !== 9'b0000_1000_1 || s_biu_type_o !== INCR8) begin
            errors++;
            $display("[TB] FAIL incr8_accept hs=%b type=%b expected hs=%b type=%b", hs, s_biu_type_o, 9'b0000_1000_1, INCR8);
        end
        for (int b = 0; b < 8; b++) begin
            if (b == 4) begin
                @(negedge clk);
                m1_biu_stb_i = 0; m0_biu_stb_i = 1; s_biu_ack_i = 0;
                #1;
                checks++;
                if (hs !== 9'b0) begin
                    errors++;
                    $display("[TB] FAIL incr8_wait hs=%b expected=%b", hs, 9'b0);
                end
            end
            @(negedge clk);
            m1_biu_stb_i = 0; m0_biu_stb_i = 1;
            s_biu_ack_i = 1; s_biu_q_i = 64'(b + 1);
            #1;
            checks++;
            if (hs !== 9'b0000_0010_0 || m1_biu_q_o !== 64'(b + 1) || s_biu_adri_o !== 64'h200) begin
                errors++;
                $display("[TB] FAIL incr8_beat%0d hs=%b q=%h adr=%h expected hs=%b q=%h adr=200", b, hs,
                         m1_biu_q_o, s_biu_adri_o, 9'b0000_0010_0, 64'(b + 1));
            end
        end
        @(negedge clk);
        s_biu_ack_i = 0;
        #1;
        checks++;
        if (hs !== 9'b1000_0000_1 || s_biu_adri_o !== 64'h300) begin
            errors++;
            $display("[TB] FAIL incr8_release hs=%b adr=%h expected hs=%b adr=300", hs, s_biu_adri_o, 9'b1000_0000_1);
        end
    endtask

    task automatic test_error();
        applyReset();
        @(negedge clk);
        m0_biu_stb_i = 1; m0_biu_adri_i = 64'h40; m0_biu_type_i = WRAP4;
        m1_biu_stb_i = 1; m1_biu_adri_i = 64'h80;
        s_biu_stb_ack_i = 1;
        #1;
        checks++;
        if (hs !== 9'b1000_0000_1) begin
            errors++;
            $display("[TB] FAIL err_accept hs=%b expected=%b", hs, 9'b1000_0000_1);
        end
        @(negedge clk);
        s_biu_stb_ack_i = 0; s_biu_ack_i = 1;
        #1;
        checks++;
        if (hs !== 9'b0010_0000_0) begin
            errors++;
            $display("[TB] FAIL err_beat1 hs=%b expected=%b", hs, 9'b0010_0000_0);
        end
        @(negedge clk);
        s_biu_ack_i = 0; s_biu_err_i = 1;
        #1;
        checks++;
        if (hs !== 9'b0001_0000_0) begin
            errors++;
            $display("[TB] FAIL err_beat2 hs=%b expected=%b", hs, 9'b0001_0000_0);
        end
        @(negedge clk);
        s_biu_err_i = 0; m0_biu_stb_i = 0; s_biu_stb_ack_i = 1;
        #1;
        checks++;
        if (hs !== 9'b0000_1000_1 || s_biu_adri_o !== 64'h80) begin
            errors++;
            $display("[TB] FAIL err_m1_accept hs=%b adr=%h expected hs=%b adr=80", hs, s_biu_adri_o, 9'b0000_1000_1);
        end
        @(negedge clk);
        s_biu_stb_ack_i = 0; s_biu_ack_i = 1; m1_biu_stb_i = 0;
        #1;
        checks++;
        if (hs !== 9'b0000_0010_0) begin
            errors++;
            $display("[TB] FAIL err_m1_ack hs=%b expected=%b", hs, 9'b0000_0010_0);
        end
        @(negedge clk);
        s_biu_ack_i = 0; m0_biu_stb_i = 1; m0_biu_type_i = SINGLE;
        #1;
        checks++;
        if (hs !== 9'b0000_0000_1) begin
            errors++;
            $display("[TB] FAIL err_final_idle hs=%b expected=%b", hs, 9'b0000_0000_1);
        end
    endtask

    task automatic test_lock();
        applyReset();
        @(negedge clk);
        m0_biu_stb_i = 1; m0_biu_lock_i = 1; m0_biu_adri_i = 64'h11;
        m1_biu_stb_i = 1; m1_biu_adri_i = 64'h22;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) @(negedge clk);
            s_biu_ack_i = 0; s_biu_stb_ack_i = 1;
            #1;
            checks++;
            if (hs !== 9'b1000_0000_1) begin
                errors++;
                $display("[TB] FAIL lock_grant%0d hs=%b expected=%b", r, hs, 9'b1000_0000_1);
            end
            @(negedge clk);
            s_biu_stb_ack_i = 0; s_biu_ack_i = 1;
            #1;
            checks++;
            if (hs !== 9'b0010_0000_0) begin
                errors++;
                $display("[TB] FAIL lock_ack%0d hs=%b expected=%b", r, hs, 9'b0010_0000_0);
            end
        end
        @(negedge clk);
        s_biu_ack_i = 0; m0_biu_stb_i = 0; m0_biu_lock_i = 0;
        @(negedge clk);
        s_biu_stb_ack_i = 1;
        #1;
        checks++;
        if (hs !== 9'b0000_1000_1 || s_biu_adri_o !== 64'h22) begin
            errors++;
            $display("[TB] FAIL lock_m1_accept hs=%b adr=%h expected hs=%b adr=22", hs, s_biu_adri_o, 9'b0000_1000_1);
        end
        @(negedge clk);
        s_biu_stb_ack_i = 0; s_biu_ack_i = 1; m1_biu_stb_i = 0;
        #1;
        checks++;
        if (hs !== 9'b0000_0010_0) begin
            errors++;
            $display("[TB] FAIL lock_m1_ack hs=%b expected=%b", hs, 9'b0000_0010_0);
        end
    endtask

    task automatic test_reset_midburst();
        applyReset();
        @(negedge clk);
        m0_biu_stb_i = 1; m0_biu_type_i = INCR16; m0_biu_adri_i = 64'h500;
        s_biu_stb_ack_i = 1;
        #1;
        checks++;
        if (hs !== 9'b1000_0000_1) begin
            errors++;
            $display("[TB] FAIL rstmid_accept hs=%b expected=%b", hs, 9'b1000_0000_1);
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            m0_biu_stb_i = 0; s_biu_stb_ack_i = 0; s_biu_ack_i = 1;
            #1;
            checks++;
            if (hs !== 9'b0010_0000_0) begin
                errors++;
                $display("[TB] FAIL rstmid_beat%0d hs=%b expected=%b", b, hs, 9'b0010_0000_0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (hs !== 9'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_in_reset hs=%b expected=%b", hs, 9'b0);
        end
        @(negedge clk);
        rst = 1'b1; s_biu_d_ack_i = 1;
        #1;
        checks++;
        if (hs !== 9'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_after hs=%b expected=%b", hs, 9'b0);
        end
        @(negedge clk);
        s_biu_ack_i = 0; s_biu_d_ack_i = 0;
        m1_biu_stb_i = 1; m1_biu_type_i = SINGLE; m1_biu_adri_i = 64'h400;
        s_biu_stb_ack_i = 1;
        #1;
        checks++;
        if (hs !== 9'b0000_1000_1 || s_biu_adri_o !== 64'h400) begin
            errors++;
            $display("[TB] FAIL rstmid_m1_accept hs=%b adr=%h expected hs=%b adr=400", hs, s_biu_adri_o, 9'b0000_1000_1);
        end
        @(negedge clk);
        m1_biu_stb_i = 0; s_biu_stb_ack_i = 0; s_biu_ack_i = 1;
        #1;
        checks++;
        if (hs !== 9'b0000_0010_0) begin
            errors++;
            $display("[TB] FAIL rstmid_m1_ack hs=%b expected=%b", hs, 9'b0000_0010_0);
        end
        @(negedge clk);
        s_biu_ack_i = 0;
        #1;
        checks++;
        if (hs !== 9'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_m1_done hs=%b expected=%b", hs, 9'b0);
        end
    endtask

    initial begin
        rst = 1'b0;
        clearInputs();
        test_reset();
        test_single_m0();
        test_simultaneous();
        test_incr8_burst();
        test_error();
        test_lock();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/peripheral_biu_arbiter.md
PERIPHERAL_BIU_ARBITER -- requirements
Module: peripheral_biu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width.
REQ-002 SHALL have parameter PLEN, default 64, address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have ports m0_/m1_biu_stb_i, _adri_i[PLEN], _size_i[3], _type_i[3], _prot_i[3], _lock_i, _we_i, _d_i[XLEN]  input  requester BIU request fields; m0 = data, m1 = instruction.
REQ-006 SHALL have ports m0_/m1_biu_stb_ack_o, _d_ack_o, _ack_o, _err_o  output  1  per-requester handshakes.
REQ-007 SHALL have ports m0_/m1_biu_q_o[XLEN], _adro_o[PLEN]  output  read data and address echo.
REQ-008 SHALL have ports s_biu_stb_o, _adri_o, _size_o, _type_o, _prot_o, _lock_o, _we_o, _d_o  output  shared-slave request fields, same widths as REQ-005.
REQ-009 SHALL have ports s_biu_stb_ack_i, _d_ack_i, _ack_i, _err_i (1), _q_i[XLEN], _adro_i[PLEN]  input  shared-slave responses.

Function
REQ-010 SHALL implement states IDLE and BUSY, plus registers owner (1 bit), beat_cnt (4 bits), lock_hold (1 bit).
REQ-011 In IDLE, winner SHALL be chosen combinationally among asserted m*_biu_stb_i; a single requester always wins; with lock_hold set, only the previous owner is eligible.
REQ-012 In IDLE, winner's request fields SHALL drive s_biu_* same cycle; s_biu_stb_o = winner's stb; non-winner sees stb_ack_o = 0.
REQ-013 winner's stb_ack_o SHALL equal s_biu_stb_ack_i in IDLE (zero added latency).
REQ-014 On s_biu_stb_ack_i = 1 in IDLE: state -> BUSY, owner <= winner, beat_cnt <= burst length-1 from type (SINGLE/INCR 0, WRAP4/INCR4 3, WRAP8/INCR8 7, WRAP16/INCR16 15).
REQ-015 In BUSY, s_biu_stb_o SHALL be 0; request fields hold owner's values (d_o tracks owner's d_i each cycle).
REQ-016 In BUSY and in the IDLE accept cycle, d_ack/ack/err SHALL be routed only to the current/accepting requester; the other requester's d_ack/ack/err/stb_ack SHALL be 0.
REQ-017 q_o and adro_o SHALL be broadcast from s_biu_q_i / s_biu_adro_i to both requesters.
REQ-018 Each s_biu_ack_i in BUSY with beat_cnt != 0 SHALL decrement beat_cnt; ack with beat_cnt == 0 SHALL return to IDLE next cycle.
REQ-019 s_biu_err_i in BUSY SHALL be forwarded to owner and force IDLE next cycle, beat_cnt <= 0, regardless of remaining beats.
REQ-020 On return to IDLE, lock_hold <= owner's lock_i; lock_hold clears when the locked owner drops stb_i in IDLE.
REQ-021 beat_cnt SHALL never underflow; arithmetic 4-bit unsigned.
REQ-022 A requester dropping stb_i in BUSY SHALL not abort the burst.

Reset
REQ-023 On rst = 0 at clk edge: state IDLE, owner 0, beat_cnt 0, lock_hold 0, RR pointer favouring m0.
REQ-024 During reset all *_stb_ack_o, *_d_ack_o, *_ack_o, *_err_o, s_biu_stb_o SHALL be 0; reset mid-burst abandons the burst with no further acks forwarded.

Configuration
REQ-025 Macro BIU_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, winner is the requester not granted last; pointer updates on each IDLE accept.
REQ-026 Macro undefined: fixed priority, m0 always wins simultaneous requests; m1 served only when m0_biu_stb_i = 0.

Verification
REQ-027 m0 SINGLE read at 0x100 alone -> m0_stb_ack same cycle as s_stb_ack; one m0_ack; m1 outputs all 0; IDLE after ack.
REQ-028 m0 and m1 both stb same cycle, each SINGLE, repeated 4 times -> with RR: grants m0,m1,m0,m1; without: m0 x4 while m0 stb held.
REQ-029 m1 INCR8 at 0x200 -> 8 s_acks forwarded to m1; m0 stb during burst sees stb_ack = 0 until 1 cycle after 8th ack.
REQ-030 m0 WRAP4, s_err_i on beat 2 -> m0_err pulse 1 cycle, IDLE next cycle, m1 pending request accepted afterwards.
REQ-031 m0 lock_i = 1 on SINGLE, m1 waiting -> m0 regranted next; m1 accepted only after m0 drops stb.
REQ-032 rst = 0 during beat 3 of INCR16 -> all handshake outputs 0 next cycle; fresh m1 SINGLE after reset completes normally.
